btn_event_gen: RTL and testbench

Debounces and edge-detects the five raw push-buttons (C, D, U, R, L) and produces the one-hot, single-cycle `btn_pulse` bus that the alarm/clock control FSM consumes. It runs entirely in the divided scan clock domain. It guarantees at most one button event per cycle by fixed-priority arbitration. It optionally generates auto-repeat events for held up/down buttons so that time and alarm digits can be scrolled.

---
 rtl/alarm_btn_pkg.sv | 30 +++
 rtl/btn_event_gen_if.sv | 13 +
 rtl/btn_debounce.sv | 39 +++
 rtl/btn_event_gen.sv | 120 ++++++++++++
 tb/tb_btn_event_gen.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alarm_btn_pkg.sv
// Button indices, one-hot codes, repeat FSM states and default timing,
// shared by btn_event_gen and the alarm/clock control FSM.
package alarm_btn_pkg;

  localparam int unsigned BTN_W = 5;

  localparam int unsigned BTN_C = 4;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_L = 0;

  localparam logic [BTN_W-1:0] BTN_C_OH = 5'b10000;
  localparam logic [BTN_W-1:0] BTN_D_OH = 5'b01000;
  localparam logic [BTN_W-1:0] BTN_U_OH = 5'b00100;
  localparam logic [BTN_W-1:0] BTN_R_OH = 5'b00010;
  localparam logic [BTN_W-1:0] BTN_L_OH = 5'b00001;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned      DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned      DEF_REPEAT_DELAY    = 100;
  localparam int unsigned      DEF_REPEAT_PERIOD   = 20;
  localparam logic [BTN_W-1:0] DEF_REPEAT_MASK     = 5'b01100;

endpackage

// File: rtl/btn_event_gen_if.sv
// Button bus between the raw pad side and the button event generator.
interface btn_event_gen_if;
  import alarm_btn_pkg::*;

  logic [BTN_W-1:0] btn_raw;
  logic [BTN_W-1:0] btn_pulse;
  logic [BTN_W-1:0] btn_level;
  logic             any_pulse;

  modport master (output btn_raw, input btn_pulse, btn_level, any_pulse);
  modport slave  (input btn_raw, output btn_pulse, btn_level, any_pulse);

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, consecutive-sample debounce counter and
// debounced level register.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_out,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q;
  logic [7:0] cnt_q;
  logic       level_q;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST_CNT) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/btn_event_gen.sv
// Debounce, press-edge detect, optional auto-repeat and fixed-priority
// (C > D > U > R > L) one-hot event arbitration. Auto-repeat: BTN_AUTOREPEAT_EN.
module btn_event_gen
  import alarm_btn_pkg::*;
#(
  parameter int unsigned      DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned      REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned      REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [BTN_W-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
  input  logic            clk_out,
  input  logic            rst,
  btn_event_gen_if.slave  bus
);

  logic [BTN_W-1:0] level;
  logic [BTN_W-1:0] level_dly_q;
  logic [BTN_W-1:0] press;
  logic [BTN_W-1:0] rpt_cand;
  logic [BTN_W-1:0] cand;
  logic [BTN_W-1:0] btn_pulse_d;
  logic [BTN_W-1:0] btn_pulse_q;
  logic             any_pulse_q;

  for (genvar g = 0; g < BTN_W; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_out (clk_out),
      .rst     (rst),
      .raw_i   (bus.btn_raw[g]),
      .level_o (level[g])
    );
  end

  assign press = level & ~level_dly_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [7:0] DELAY_T  = 8'(REPEAT_DELAY);
  localparam logic [7:0] PERIOD_T = 8'(REPEAT_PERIOD);

  for (genvar g = 0; g < BTN_W; g++) begin : g_rpt
    if (REPEAT_MASK[g]) begin : g_on
      rpt_state_e state_q;
      logic [7:0] timer_q;

      // Repeat event is decoded in the cycle before it is registered into
      // btn_pulse, so it lands exactly REPEAT_DELAY/PERIOD after the last one.
      assign rpt_cand[g] = ((state_q == RPT_DELAY)  && (timer_q == DELAY_T)) ||
                           ((state_q == RPT_REPEAT) && (timer_q == PERIOD_T));

      always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
          state_q <= RPT_IDLE;
          timer_q <= '0;
        end else if (!level[g]) begin
          state_q <= RPT_IDLE;
          timer_q <= '0;
        end else begin
          case (state_q)
            RPT_IDLE: begin
              if (press[g]) begin
                state_q <= RPT_DELAY;
                timer_q <= 8'd1;
              end
            end
            RPT_DELAY: begin
              if (timer_q == DELAY_T) begin
                state_q <= RPT_REPEAT;
                timer_q <= 8'd1;
              end else begin
                timer_q <= timer_q + 8'd1;
              end
            end
            RPT_REPEAT: begin
              if (timer_q == PERIOD_T) timer_q <= 8'd1;
              else                     timer_q <= timer_q + 8'd1;
            end
            default: begin
              state_q <= RPT_IDLE;
              timer_q <= '0;
            end
          endcase
        end
      end
    end else begin : g_off
      assign rpt_cand[g] = 1'b0;
    end
  end
`else
  assign rpt_cand = '0;
`endif

  assign cand = press | rpt_cand;

  always_comb begin
    btn_pulse_d = '0;
    for (int unsigned i = 0; i < BTN_W; i++) begin
      if (cand[i]) begin
        btn_pulse_d    = '0;
        btn_pulse_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      level_dly_q <= '0;
      btn_pulse_q <= '0;
      any_pulse_q <= 1'b0;
    end else begin
      level_dly_q <= level;
      btn_pulse_q <= btn_pulse_d;
      any_pulse_q <= |btn_pulse_d;
    end
  end

  assign bus.btn_pulse = btn_pulse_q;
  assign bus.btn_level = level;
  assign bus.any_pulse = any_pulse_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; repeat scenarios follow BTN_AUTOREPEAT_EN.
module tb_btn_event_gen;
  import alarm_btn_pkg::*;

  logic clk_out = 1'b0;
  logic rst     = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  btn_event_gen_if bus ();

  btn_event_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (5'b01100)
  ) dut (
    .clk_out (clk_out),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_out = ~clk_out;

  task automatic tick;
    @(posedge clk_out);
    #1;
  endtask

  task automatic quiesce;
    bus.btn_raw = '0;
    repeat (12) tick;
  endtask

  task automatic test_reset;
    bus.btn_raw = '0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.btn_pulse !== '0) begin n_err++; $display("FAIL reset_pulse: got %b want 00000", bus.btn_pulse); end
    n_cmp++; if (bus.btn_level !== '0) begin n_err++; $display("FAIL reset_level: got %b want 00000", bus.btn_level); end
    n_cmp++; if (bus.any_pulse !== 1'b0) begin n_err++; $display("FAIL reset_any: got %b want 0", bus.any_pulse); end
    repeat (3) tick;
    rst = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_press_u;
    logic [4:0] exp_p;
    bus.btn_raw = BTN_U_OH;
    for (int i = 1; i <= 12; i++) begin
      tick;
      exp_p = (i == 7) ? BTN_U_OH : 5'b00000;
      n_cmp++; if (bus.btn_pulse !== exp_p) begin n_err++; $display("FAIL press_u_pulse cyc%0d: got %b want %b", i, bus.btn_pulse, exp_p); end
      n_cmp++; if (bus.any_pulse !== (i == 7)) begin n_err++; $display("FAIL press_u_any cyc%0d: got %b want %b", i, bus.any_pulse, (i == 7)); end
      if (i == 5 || i == 6) begin
        n_cmp++; if (bus.btn_level[BTN_U] !== (i == 6)) begin n_err++; $display("FAIL press_u_level cyc%0d: got %b want %b", i, bus.btn_level[BTN_U], (i == 6)); end
      end
    end
    bus.btn_raw = '0;
    for (int i = 1; i <= 10; i++) begin
      tick;
`ifdef BTN_AUTOREPEAT_EN
      exp_p = (i == 5) ? BTN_U_OH : 5'b00000;
`else
      exp_p = 5'b00000;
`endif
      n_cmp++; if (bus.btn_pulse !== exp_p) begin n_err++; $display("FAIL release_u_pulse cyc%0d: got %b want %b", i, bus.btn_pulse, exp_p); end
    end
    n_cmp++; if (bus.btn_level !== '0) begin n_err++; $display("FAIL release_u_level: got %b want 00000", bus.btn_level); end
    quiesce;
  endtask

  task automatic test_bounce_c;
    logic [4:0] exp_p;
    for (int i = 0; i < 6; i++) begin
      bus.btn_raw = (i % 2 == 0) ? BTN_C_OH : 5'b00000;
      tick;
      n_cmp++; if (bus.btn_pulse !== '0) begin n_err++; $display("FAIL bounce_c_quiet cyc%0d: got %b want 00000", i, bus.btn_pulse); end
    end
    bus.btn_raw = BTN_C_OH;
    for (int i = 1; i <= 12; i++) begin
      tick;
      exp_p = (i == 7) ? BTN_C_OH : 5'b00000;
      n_cmp++; if (bus.btn_pulse !== exp_p) begin n_err++; $display("FAIL bounce_c_pulse cyc%0d: got %b want %b", i, bus.btn_pulse, exp_p); end
    end
    quiesce;
  endtask

  task automatic test_simultaneous;
    logic [4:0] exp_p;
    bus.btn_raw = BTN_C_OH | BTN_L_OH;
    for (int i = 1; i <= 12; i++) begin
      tick;
      exp_p = (i == 7) ? BTN_C_OH : 5'b00000;
      n_cmp++; if (bus.btn_pulse !== exp_p) begin n_err++; $display("FAIL simul_pulse cyc%0d: got %b want %b", i, bus.btn_pulse, exp_p); end
    end
    n_cmp++; if (bus.btn_level !== 5'b10001) begin n_err++; $display("FAIL simul_level: got %b want 10001", bus.btn_level); end
    bus.btn_raw = '0;
    for (int i = 1; i <= 10; i++) begin
      tick;
      n_cmp++; if (bus.btn_pulse !== '0) begin n_err++; $display("FAIL simul_no_late_l cyc%0d: got %b want 00000", i, bus.btn_pulse); end
    end
    quiesce;
  endtask

  task automatic test_glitch_filter;
    bus.btn_raw = BTN_C_OH;
    repeat (12) tick;
    n_cmp++; if (bus.btn_level !== BTN_C_OH) begin n_err++; $display("FAIL glitch_pre_level: got %b want %b", bus.btn_level, BTN_C_OH); end
    bus.btn_raw = '0;
    for (int i = 1; i <= 17; i++) begin
      if (i == 3) bus.btn_raw = BTN_C_OH;
      tick;
      n_cmp++; if (bus.btn_pulse !== '0) begin n_err++; $display("FAIL glitch_pulse cyc%0d: got %b want 00000", i, bus.btn_pulse); end
      n_cmp++; if (bus.btn_level !== BTN_C_OH) begin n_err++; $display("FAIL glitch_level cyc%0d: got %b want %b", i, bus.btn_level, BTN_C_OH); end
    end
    quiesce;
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat;
    logic [4:0] exp_p;
    bus.btn_raw = BTN_D_OH;
    for (int i = 1; i <= 27; i++) begin
      tick;
      exp_p = (i == 7 || i == 17 || i == 20 || i == 23 || i == 26) ? BTN_D_OH : 5'b00000;
      n_cmp++; if (bus.btn_pulse !== exp_p) begin n_err++; $display("FAIL repeat_d_pulse cyc%0d: got %b want %b", i, bus.btn_pulse, exp_p); end
      n_cmp++; if (bus.any_pulse !== (exp_p != 5'b00000)) begin n_err++; $display("FAIL repeat_d_any cyc%0d: got %b", i, bus.any_pulse); end
    end
    quiesce;
    bus.btn_raw = BTN_R_OH;
    for (int i = 1; i <= 27; i++) begin
      tick;
      exp_p = (i == 7) ? BTN_R_OH : 5'b00000;
      n_cmp++; if (bus.btn_pulse !== exp_p) begin n_err++; $display("FAIL norepeat_r_pulse cyc%0d: got %b want %b", i, bus.btn_pulse, exp_p); end
    end
    quiesce;
  endtask

  task automatic test_reset_mid_repeat;
    logic [4:0] exp_p;
    bus.btn_raw = BTN_U_OH;
    repeat (20) tick;
    n_cmp++; if (bus.btn_pulse !== BTN_U_OH) begin n_err++; $display("FAIL mid_pre_pulse: got %b want %b", bus.btn_pulse, BTN_U_OH); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.btn_pulse !== '0) begin n_err++; $display("FAIL mid_rst_pulse: got %b want 00000", bus.btn_pulse); end
    n_cmp++; if (bus.btn_level !== '0) begin n_err++; $display("FAIL mid_rst_level: got %b want 00000", bus.btn_level); end
    n_cmp++; if (bus.any_pulse !== 1'b0) begin n_err++; $display("FAIL mid_rst_any: got %b want 0", bus.any_pulse); end
    repeat (2) tick;
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      exp_p = (i == 7 || i == 17 || i == 20) ? BTN_U_OH : 5'b00000;
      n_cmp++; if (bus.btn_pulse !== exp_p) begin n_err++; $display("FAIL post_rst_pulse cyc%0d: got %b want %b", i, bus.btn_pulse, exp_p); end
    end
    quiesce;
  endtask
`else
  task automatic test_no_repeat;
    int pulses;
    pulses = 0;
    bus.btn_raw = BTN_D_OH;
    for (int i = 1; i <= 200; i++) begin
      tick;
      if (bus.btn_pulse !== '0) pulses++;
      if (i == 7) begin
        n_cmp++; if (bus.btn_pulse !== BTN_D_OH) begin n_err++; $display("FAIL hold_d_first: got %b want %b", bus.btn_pulse, BTN_D_OH); end
      end
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL hold_d_count: got %0d want 1", pulses); end
    quiesce;
  endtask
`endif

  initial begin
    bus.btn_raw = '0;
    test_reset;
    test_press_u;
    test_bounce_c;
    test_simultaneous;
    test_glitch_filter;
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat;
    test_reset_mid_repeat;
`else
    test_no_repeat;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
